// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: simple dual-port RAM with one write port, one read port and one clock.
// Writes are byte-lane masked. Reads are pipelined with a valid flag. Read latency is
// 1 or 2 cycles (OUT_REG). Same-address read-during-write returns either the old word
// or the merged new word (RDW_MODE).
module dual_port_ram_be #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 32,
    parameter int LANE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH/LANE_W-1:0]   wr_be,
    input  logic [DEPTH-1:0]          wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [DEPTH-1:0]          rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid
);

    localparam int NUM_LANES = WIDTH / LANE_W;
    localparam int NUM_WORDS = 1 << DEPTH;

    // A word must split into a whole number of lanes; anything else is a configuration error.
    generate
        if (WIDTH % LANE_W != 0) begin : g_bad_lane_width
            $error("dual_port_ram_be: WIDTH must be a multiple of LANE_W");
        end
    endgenerate

    // Storage array; deliberately not reset, contents are undefined until written.
    logic [WIDTH-1:0] mem_q [0:NUM_WORDS-1];

    // First read stage: captured word and its valid flag.
    logic             valid1_q, valid1_d;
    logic [WIDTH-1:0] data1_q,  data1_d;

    // Word presented to the read port this edge, including optional same-address forwarding.
    logic [WIDTH-1:0] rdWord;

    // Masked write; an edge with reset high performs no write.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read word: pre-write array word, with enabled write lanes forwarded when new-data mode is chosen.
    always_comb begin
        rdWord = mem_q[rd_addr];
        if ((RDW_MODE != 0) && wr_en && (rd_addr == wr_addr)) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_be[i]) begin
                    rdWord[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Stage-1 next state: valid follows rd_en, data only updates on a real read so it holds otherwise.
    always_comb begin
        valid1_d = rd_en;
        data1_d  = data1_q;
        if (rd_en) begin
            data1_d = rdWord;
        end
    end

    // Stage-1 registers; reset drops any in-flight read immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            data1_q  <= '0;
        end else begin
            valid1_q <= valid1_d;
            data1_q  <= data1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             valid2_q, valid2_d;
            logic [WIDTH-1:0] data2_q,  data2_d;

            // Stage-2 next state: advance the stage-1 result, holding data when nothing valid arrives.
            always_comb begin
                valid2_d = valid1_q;
                data2_d  = data2_q;
                if (valid1_q) begin
                    data2_d = data1_q;
                end
            end

            // Stage-2 output register; cleared asynchronously with the rest of the pipeline.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid2_q <= 1'b0;
                    data2_q  <= '0;
                end else begin
                    valid2_q <= valid2_d;
                    data2_q  <= data2_d;
                end
            end

            assign rd_valid = valid2_q;
            assign rd_data  = data2_q;
        end else begin : g_no_out_reg
            assign rd_valid = valid1_q;
            assign rd_data  = data1_q;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be: drives two RAM instances with shared inputs. Instance A is
// old-data / latency 1, instance B is new-data / latency 2. Expected values are hand-computed.
module tb_dual_port_ram_be;

    typedef struct {
        logic        wrEn;
        logic [3:0]  wrBe;
        logic [7:0]  wrAddr;
        logic [31:0] wrData;
        logic        rdEn;
        logic [7:0]  rdAddr;
        logic        expValid;
        logic [31:0] expData0;
        logic [31:0] expData1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [3:0]  wrBe;
    logic [7:0]  wrAddr;
    logic [31:0] wrData;
    logic        rdEn;
    logic [7:0]  rdAddr;
    logic [31:0] rdDataA, rdDataB;
    logic        rdValidA, rdValidB;

    int testsRun    = 0;
    int testsFailed = 0;

    vec_t vecs[$];
    vec_t prevVec;
    vec_t idleVec;

    dual_port_ram_be #(.DEPTH(8), .WIDTH(32), .LANE_W(8), .RDW_MODE(0), .OUT_REG(0)) dutA (
        .clk(clk), .rst(rst),
        .wr_en(wrEn), .wr_be(wrBe), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_valid(rdValidA)
    );

    dual_port_ram_be #(.DEPTH(8), .WIDTH(32), .LANE_W(8), .RDW_MODE(1), .OUT_REG(1)) dutB (
        .clk(clk), .rst(rst),
        .wr_en(wrEn), .wr_be(wrBe), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_valid(rdValidB)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic we, logic [3:0] be, logic [7:0] wa, logic [31:0] wd,
                                logic re, logic [7:0] ra, logic ev, logic [31:0] e0,
                                logic [31:0] e1);
        vec_t v;
        v.wrEn = we; v.wrBe = be; v.wrAddr = wa; v.wrData = wd;
        v.rdEn = re; v.rdAddr = ra;
        v.expValid = ev; v.expData0 = e0; v.expData1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        wrEn   = v.wrEn;
        wrBe   = v.wrBe;
        wrAddr = v.wrAddr;
        wrData = v.wrData;
        rdEn   = v.rdEn;
        rdAddr = v.rdAddr;
    endtask

    task automatic checkOutput(input vec_t cur, input vec_t prev, input int idx);
        check($sformatf("A valid vec%0d", idx), {31'b0, rdValidA}, {31'b0, cur.expValid});
        if (cur.expValid) check($sformatf("A data vec%0d", idx), rdDataA, cur.expData0);
        check($sformatf("B valid vec%0d", idx), {31'b0, rdValidB}, {31'b0, prev.expValid});
        if (prev.expValid) check($sformatf("B data vec%0d", idx), rdDataB, prev.expData1);
    endtask

    initial begin
        rst = 1'b1; wrEn = 0; wrBe = 0; wrAddr = 0; wrData = 0; rdEn = 0; rdAddr = 0;
        idleVec = mk(0, 4'h0, 8'h00, 32'h0, 0, 8'h00, 0, 32'h0, 32'h0);

        // Reset: three cycles with rd_en toggling, outputs stay cleared.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rdEn = ~rdEn;
            @(posedge clk); #1;
            check("reset A valid", {31'b0, rdValidA}, 32'h0);
            check("reset A data",  rdDataA, 32'h0);
            check("reset B valid", {31'b0, rdValidB}, 32'h0);
            check("reset B data",  rdDataB, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0; rdEn = 1'b0;

        // Lane mask
        vecs.push_back(mk(1, 4'hF, 8'h10, 32'hAABBCCDD, 0, 8'h00, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 4'h5, 8'h10, 32'h11223344, 0, 8'h00, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 4'hF, 8'h05, 32'h00000000, 0, 8'h00, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'h10, 1, 32'hAA22CC44, 32'hAA22CC44));
        // Read-during-write, then a follow-up read
        vecs.push_back(mk(1, 4'h3, 8'h05, 32'hFFFFFFFF, 1, 8'h05, 1, 32'h00000000, 32'h0000FFFF));
        vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'h05, 1, 32'h0000FFFF, 32'h0000FFFF));
        vecs.push_back(idleVec);
        // Streaming: preload then read back-to-back
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 4'hF, 8'(k), 32'(k) * 32'h01010101, 0, 8'h00, 0, 32'h0, 32'h0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'(k), 1,
                              32'(k) * 32'h01010101, 32'(k) * 32'h01010101));
        // Boundary address, address 0 untouched
        vecs.push_back(mk(1, 4'hF, 8'h00, 32'h12345678, 0, 8'h00, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 4'hF, 8'hFF, 32'hDEADBEEF, 0, 8'h00, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'hFF, 1, 32'hDEADBEEF, 32'hDEADBEEF));
        vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'h00, 1, 32'h12345678, 32'h12345678));
        vecs.push_back(idleVec);
        // Simultaneous read and write to different addresses
        vecs.push_back(mk(1, 4'hF, 8'h01, 32'h55555555, 1, 8'h02, 1, 32'h02020202, 32'h02020202));
        vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'h01, 1, 32'h55555555, 32'h55555555));
        vecs.push_back(idleVec);

        prevVec = idleVec;
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            @(posedge clk); #1;
            checkOutput(vecs[k], prevVec, k);
            prevVec = vecs[k];
        end
        applyStimulus(idleVec);
        @(posedge clk); #1;
        checkOutput(idleVec, prevVec, vecs.size());

        // Hold: no reads for 4 cycles while the array changes underneath
        for (int c = 0; c < 4; c++) begin
            if (c == 0) applyStimulus(mk(1, 4'hF, 8'h01, 32'h0, 0, 8'h00, 0, 32'h0, 32'h0));
            else        applyStimulus(idleVec);
            @(posedge clk); #1;
            check("hold A valid", {31'b0, rdValidA}, 32'h0);
            check("hold A data",  rdDataA, 32'h55555555);
            check("hold B valid", {31'b0, rdValidB}, 32'h0);
            check("hold B data",  rdDataB, 32'h55555555);
        end

        // Reset mid-read: B's pending read must never emerge
        applyStimulus(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'h03, 1, 32'h0, 32'h0));
        @(posedge clk); #1;
        check("midrst A valid", {31'b0, rdValidA}, 32'h1);
        check("midrst A data",  rdDataA, 32'h03030303);
        check("midrst B not yet valid", {31'b0, rdValidB}, 32'h0);
        @(negedge clk);
        rdEn = 1'b0;
        rst  = 1'b1;
        #1;
        check("midrst A async clear", {31'b0, rdValidA}, 32'h0);
        check("midrst A data clear",  rdDataA, 32'h0);
        check("midrst B async clear", {31'b0, rdValidB}, 32'h0);
        check("midrst B data clear",  rdDataB, 32'h0);
        @(posedge clk); #1;
        check("midrst B in reset", {31'b0, rdValidB}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(idleVec);
            @(posedge clk); #1;
            check("midrst B no late pulse", {31'b0, rdValidB}, 32'h0);
        end
        applyStimulus(mk(0, 4'h0, 8'h00, 32'h0, 1, 8'h03, 1, 32'h0, 32'h0));
        @(posedge clk); #1;
        check("postrst A valid", {31'b0, rdValidA}, 32'h1);
        check("postrst A data",  rdDataA, 32'h03030303);
        check("postrst B latency", {31'b0, rdValidB}, 32'h0);
        applyStimulus(idleVec);
        @(posedge clk); #1;
        check("postrst A done",  {31'b0, rdValidA}, 32'h0);
        check("postrst B valid", {31'b0, rdValidB}, 32'h1);
        check("postrst B data",  rdDataB, 32'h03030303);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
